// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the byte-serial adder.
// SEQ_ADDER_SUB_EN (optional) enables the subtract mode in seq_adder.
package seq_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow of an addition x + y = s, given the three sign bits.
  // Subtraction reuses it with y already inverted.
  function automatic logic add_ovf(input logic x_sign, input logic y_sign,
                                   input logic s_sign);
    return (x_sign ~^ y_sign) & (s_sign ^ x_sign);
  endfunction

endpackage

// File: rtl/byte_add_cell.sv
// One byte slice of the carry chain: s/co = x + y + ci.
import seq_adder_pkg::*;

module byte_add_cell (
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  // Nine-bit add; the top bit becomes the carry into the next byte.
  always_comb begin
    {co, s} = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, ci};
  end

endmodule

// File: rtl/seq_adder.sv
// Byte-serial multi-precision adder, LSB byte first, one byte per cycle.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready in this block.
// Define SEQ_ADDER_SUB_EN to add the op_sub port (a - b - borrow-in mode).
import seq_adder_pkg::*;

module seq_adder #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*NBYTES-1:0]  a,
  input  logic [8*NBYTES-1:0]  b,
  input  logic                 cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic                 op_sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*NBYTES-1:0]  sum,
  output logic                 cout,
  output logic                 overflow,
  output state_e               dbg_state_o
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;    // holds ~b when subtracting
  logic [W-1:0]       sum_q;
  logic [W-1:0]       sum_d;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cout_q;
  logic               ovf_q;
  logic               sub_q;
  logic               last_byte;

  logic [BYTE_W-1:0]  cell_x;
  logic [BYTE_W-1:0]  cell_y;
  logic [BYTE_W-1:0]  cell_s;
  logic               cell_co;

`ifndef SEQ_ADDER_SUB_EN
  assign sub_q = 1'b0;
`endif

  // Pick the operand bytes for the current index and splice the result in.
  always_comb begin
    cell_x = '0;
    cell_y = '0;
    sum_d  = sum_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cell_x = a_q[i*BYTE_W +: BYTE_W];
        cell_y = b_q[i*BYTE_W +: BYTE_W];
        sum_d[i*BYTE_W +: BYTE_W] = cell_s;
      end
    end
  end

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  byte_add_cell u_cell (
    .x  (cell_x),
    .y  (cell_y),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Control FSM, operand capture and the registered carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            idx_q <= '0;
`ifdef SEQ_ADDER_SUB_EN
            sub_q   <= op_sub;
            b_q     <= op_sub ? ~b : b;
            carry_q <= cin ^ op_sub;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= cell_co;
          if (last_byte) begin
            idx_q   <= '0;
            cout_q  <= cell_co ^ sub_q;
            ovf_q   <= add_ovf(a_q[W-1], b_q[W-1], cell_s[BYTE_W-1]);
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder (NBYTES=4): directed cases then random ops
// against an arithmetic reference model.
import seq_adder_pkg::*;

module tb_seq_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          cin;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  state_e        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  seq_adder #(.NBYTES(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SEQ_ADDER_SUB_EN
    .op_sub      (op_sub),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: whole-word arithmetic straight from the rules.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mc, input logic msub,
                       output logic [W-1:0] es, output logic ec,
                       output logic eo);
    logic [W:0] full;
    if (msub) begin
      full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
      es = full[W-1:0];
      ec = ({1'b0, ma} < ({1'b0, mb} + {{W{1'b0}}, mc}));
      eo = (ma[W-1] ^ mb[W-1]) & (es[W-1] ^ ma[W-1]);
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      es = full[W-1:0];
      ec = full[W];
      eo = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
    end
  endtask

  // Driver: issue one operation, check latency and result, complete handshake.
  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_, input logic tc,
                        input logic tsub, input int stall);
    logic [W-1:0] es;
    logic ec, eo;
    int n;
    model(ta, tb_, tc, tsub, es, ec, eo);
    exp_q.push_back(es);
    @(negedge clk);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_; cin = tc; op_sub = tsub;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NB));
    for (int i = 0; i < stall; i++) begin
      check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    check({tag, "_sum"}, 64'(sum), 64'(exp_q.pop_front()));
    check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_released"}, {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic held_c, held_o;
    logic [W-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    op_sub = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout_ovf", {62'd0, cout, overflow}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases
    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    run_op("cin_only", 32'h0, 32'h0, 1'b1, 1'b0, 0);
    run_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);

    // Stall in DONE: result stable, extra in_valid pulse ignored
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NB) @(negedge clk);
    check("stall_valid", {63'd0, out_valid}, 64'd1);
    check("stall_sum0", 64'(sum), 64'h2345_678A);
    held_sum = sum; held_c = cout; held_o = overflow;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a = 32'hDEAD_BEEF; b = 32'h1; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      check("stall_hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_hold_sum", 64'(sum), 64'(held_sum));
      check("stall_hold_flags", {62'd0, cout, overflow}, {62'd0, held_c, held_o});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_back_idle", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    check("stall_no_accept", {63'd0, in_ready}, 64'd1);

    // Reset during the second ADD cycle
    a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'h89AB_CDEF, 32'h7654_3211, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid held high: accept on first IDLE cycle
    @(negedge clk);
    a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (NB + 1) @(negedge clk);
    check("b2b_first_sum", 64'(sum), 64'h30);
    check("b2b_first_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    check("b2b_idle_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_reaccepted", {63'd0, in_ready}, 64'd0);
    repeat (NB) @(negedge clk);
    check("b2b_second_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;

`ifdef SEQ_ADDER_SUB_EN
    run_op("sub_borrow", 32'h0, 32'h1, 1'b0, 1'b1, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 0);
    run_op("sub_bin", 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b1, 1);
`endif

    // Random operations with random result back-pressure
    for (int k = 0; k < 25; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 5 == 0) rb = ~ra;
`ifdef SEQ_ADDER_SUB_EN
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
`else
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'b0,
             $urandom_range(0, 3));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_adder.md
Name: seq_adder

Overview:
- Byte-serial multi-precision adder. It is the addition-direction companion to the team's 8-bit borrow subtractor.
- Accepts two NBYTES-wide operands plus carry-in through a valid/ready handshake.
- Computes the sum one byte per cycle, least-significant byte first, through a registered carry chain.
- Presents the sum, carry-out and signed overflow on a valid/ready result port. Sits in the ALU datapath for wide (16/32/64-bit) arithmetic.

Parameters:
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 1..16.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry-in to byte 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  carry out of the top byte
- overflow  out  1  signed two's-complement overflow of the full W-bit add

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. Asserting rst at any time, including mid-ADD, forces the following immediately:
  - state=IDLE, in_ready=1, out_valid=0
  - sum=0, cout=0, overflow=0
  - internal carry=0, byte index=0
- State machine:
  - IDLE -> ADD on in_valid & in_ready. a, b and cin are captured into registers, carry<=cin and idx<=0. sum keeps its old value until overwritten.
  - ADD: each cycle, sum[8*idx +: 8] <= a_r byte idx + b_r byte idx + carry (9-bit result). carry <= bit 8 of that result, idx <= idx+1.
    - When idx==NBYTES-1, go to DONE at that edge.
    - In the same edge, set cout to the final carry.
    - In the same edge, set overflow = (a_r[W-1] ~^ b_r[W-1]) & (new sum[W-1] ^ a_r[W-1]).
  - DONE: out_valid=1. sum, cout and overflow stay stable while out_ready=0. On out_valid & out_ready, go to IDLE.
- Handshake:
  - in_ready = (state==IDLE), driven combinationally from state.
  - Inputs are sampled only on the accept edge; changes at other times are ignored.
  - in_valid is ignored while busy. There is no overlap and no input buffering: a new accept can occur at the earliest one cycle after the result handshake.
- Latency: accept at edge k; out_valid rises after edge k+NBYTES. Throughput is one operation per NBYTES+2 cycles.
- Arithmetic:
  - The sum is modulo 2^W.
  - cout is the unsigned carry out of bit W-1.
  - When NBYTES=1, the block behaves as a single-cycle-compute 8-bit adder.
- Boundaries:
  - out_ready held high in DONE: exactly one handshake cycle.
  - in_valid high continuously: the next operation is accepted in the first IDLE cycle.
  - rst during DONE discards the result.

Optional Feature:
- Macro: SEQ_ADDER_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), captured at accept.
  - When op_sub=1, the block computes a - b - cin, where cin is treated as borrow-in. The datapath adds ~b with initial carry = ~cin.
  - cout reports borrow-out (inverted final carry).
  - overflow = (a_sign ^ b_sign) & (sum_sign ^ a_sign).
  - When op_sub=0, behaviour is identical to the undefined case.
- Undefined: no op_sub port; the block only adds.

Decomposition:
- Package seq_adder_pkg holds:
  - BYTE_W=8
  - state enum typedef {IDLE, ADD, DONE}
  - helper function for the signed-overflow term
- One natural sub-module: byte_add_cell. It is combinational, with inputs 8-bit x, 8-bit y and ci, and outputs 8-bit s and co. The FSM, index counter and operand registers stay in seq_adder.

Test Plan (NBYTES=4):
- a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> after 4 ADD cycles: sum=0x00000000, cout=1, overflow=0; out_valid rises exactly 4 cycles after accept.
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, overflow=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, overflow=1.
- a=0, b=0, cin=1 -> sum=0x00000001. a=0x000000FF, b=0x00000001 -> carry propagates: sum=0x00000100.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, sum/cout/overflow stable, in_ready=0, and a second in_valid pulse is ignored.
- Assert rst during the 2nd ADD cycle -> immediately out_valid=0, in_ready=1, sum=0. A new operation afterwards completes correctly.
- With SEQ_ADDER_SUB_EN and op_sub=1: a=0, b=1, cin=0 -> sum=0xFFFFFFFF, cout(borrow)=1. a=0x80000000, b=1 -> sum=0x7FFFFFFF, overflow=1.
